// File: rtl/mips_defs_pkg.sv
// Shared MIPS encoding constants, request kinds and loader FSM states.
// Also used by the main control decoder, so opcode/func values live here only once.
package mips_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FUNC_ADD = 6'h20;
  localparam logic [5:0] FUNC_SUB = 6'h22;
  localparam logic [5:0] FUNC_AND = 6'h24;
  localparam logic [5:0] FUNC_OR  = 6'h25;

  typedef enum logic [2:0] {
    KIND_ADD     = 3'd0,
    KIND_SUB     = 3'd1,
    KIND_AND     = 3'd2,
    KIND_OR      = 3'd3,
    KIND_LW      = 3'd4,
    KIND_SW      = 3'd5,
    KIND_BEQ     = 3'd6,
    KIND_ILLEGAL = 3'd7
  } req_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] rtype_word(input logic [4:0] rs, input logic [4:0] rt,
                                             input logic [4:0] rd, input logic [5:0] func);
    return {OP_RTYPE, rs, rt, rd, 5'd0, func};
  endfunction

  function automatic logic [31:0] itype_word(input logic [5:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational encoder: symbolic request fields -> 32-bit MIPS word plus illegal flag.
module instr_encode
  import mips_defs_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (req_kind_t'(kind))
      KIND_ADD:     word = rtype_word(rs, rt, rd, FUNC_ADD);
      KIND_SUB:     word = rtype_word(rs, rt, rd, FUNC_SUB);
      KIND_AND:     word = rtype_word(rs, rt, rd, FUNC_AND);
      KIND_OR:      word = rtype_word(rs, rt, rd, FUNC_OR);
      KIND_LW:      word = itype_word(OP_LW, rs, rt, imm);
      KIND_SW:      word = itype_word(OP_SW, rs, rt, imm);
      KIND_BEQ:     word = itype_word(OP_BEQ, rs, rt, imm);
      KIND_ILLEGAL: illegal = 1'b1;
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Accepts symbolic instruction requests and streams the encoded words into the
// instruction memory write port, one word every two cycles.
module instr_encoder_loader
  import mips_defs_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_kind,
  input  logic [4:0]            req_rs,
  input  logic [4:0]            req_rt,
  input  logic [4:0]            req_rd,
  input  logic [15:0]           req_imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err_illegal,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A   = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                state;
  logic                  finish_pending;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [31:0]           enc_word;
  logic                  enc_illegal;
  logic                  hs;

  instr_encode u_encode (
    .kind    (req_kind),
    .rs      (req_rs),
    .rt      (req_rt),
    .rd      (req_rd),
    .imm     (req_imm),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign full      = (count == DEPTH_C);
  assign req_ready = (state == ST_LOAD) && !full;
  assign imem_we   = (state == ST_WRITE);
  assign done      = (state == ST_DONE);
  assign hs        = req_valid && req_ready;

  // start overrides everything; a write already in flight still strobes this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      count          <= '0;
      wr_ptr         <= BASE_A;
      imem_addr      <= '0;
      imem_wdata     <= '0;
      err_illegal    <= 1'b0;
      finish_pending <= 1'b0;
    end else if (start) begin
      state          <= ST_LOAD;
      count          <= '0;
      wr_ptr         <= BASE_A;
      err_illegal    <= 1'b0;
      finish_pending <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (finish) finish_pending <= 1'b1;
          if (hs) begin
            if (enc_illegal) begin
              err_illegal <= 1'b1;
            end else begin
              imem_addr  <= wr_ptr;
              imem_wdata <= enc_word;
              state      <= ST_WRITE;
            end
          end else if (finish_pending) begin
            state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          if (finish) finish_pending <= 1'b1;
          count  <= count + CNT_ONE;
          wr_ptr <= wr_ptr + ADDR_ONE;
          state  <= ST_LOAD;
        end
        ST_DONE: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a write scoreboard (DEPTH=4, BASE_ADDR=0xFE).
module tb_instr_encoder_loader;

  localparam int AW      = 8;
  localparam int TB_DEPTH = 4;
  localparam int TB_BASE = 8'hFE;
  localparam int HS_LIMIT = 40;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] word;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          finish;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_kind;
  logic [4:0]    req_rs;
  logic [4:0]    req_rt;
  logic [4:0]    req_rd;
  logic [15:0]   req_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err_illegal;
  logic          done;

  int   errors = 0;
  int   checks = 0;
  int   mcount = 0;
  int   cyc = 0;
  int   last_we_cyc = 0;
  int   last_gap = 0;
  logic prev_we = 1'b0;
  exp_t sb[$];

  instr_encoder_loader #(
    .ADDR_WIDTH (AW),
    .DEPTH      (TB_DEPTH),
    .BASE_ADDR  (TB_BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .finish      (finish),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_kind    (req_kind),
    .req_rs      (req_rs),
    .req_rt      (req_rt),
    .req_rd      (req_rd),
    .req_imm     (req_imm),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .count       (count),
    .full        (full),
    .err_illegal (err_illegal),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_word(input logic [2:0] k, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [15:0] imm);
    case (k)
      3'd0:    return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      3'd1:    return {6'h00, rs, rt, rd, 5'd0, 6'h22};
      3'd2:    return {6'h00, rs, rt, rd, 5'd0, 6'h24};
      3'd3:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      3'd4:    return {6'h23, rs, rt, imm};
      3'd5:    return {6'h2B, rs, rt, imm};
      3'd6:    return {6'h04, rs, rt, imm};
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mcount = 0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic apply_stimulus(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [15:0] imm,
                                input logic [31:0] exp_word, input bit keep, input bit fin);
    int   n = 0;
    exp_t e;
    req_kind  = kind;
    req_rs    = rs;
    req_rt    = rt;
    req_rd    = rd;
    req_imm   = imm;
    req_valid = 1'b1;
    finish    = fin;
    while (!req_ready && n < HS_LIMIT) begin
      @(negedge clk);
      n++;
    end
    check_output("hs_timeout", 64'(n < HS_LIMIT), 64'd1);
    if (n < HS_LIMIT) begin
      if (kind != 3'd7) begin
        e.addr = 8'(TB_BASE + mcount);
        e.word = exp_word;
        sb.push_back(e);
        mcount++;
      end
      @(negedge clk);
    end
    if (!keep) req_valid = 1'b0;
    finish = 1'b0;
  endtask

  // Write monitor: every strobe must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (imem_we) begin
        check_output("we_single_cycle", 64'(prev_we), 64'd0);
        if (sb.size() == 0) begin
          check_output("unexpected_write", {56'd0, imem_addr}, 64'hFFFF);
        end else begin
          e = sb.pop_front();
          check_output("write_addr", 64'(imem_addr), 64'(e.addr));
          check_output("write_data", 64'(imem_wdata), 64'(e.word));
        end
        last_gap    = cyc - last_we_cyc;
        last_we_cyc = cyc;
      end
      prev_we = imem_we;
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; req_valid = 1'b0;
    req_kind = 3'd0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs",
                 64'({req_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal, done}), 64'd0);
    rst_n = 1'b1;

    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check_output("idle_not_ready", 64'(req_ready), 64'd0);
    req_valid = 1'b0;

    pulse_start();
    check_output("load_ready", 64'(req_ready), 64'd1);
    apply_stimulus(3'd0, 5'd1, 5'd2, 5'd3, 16'h1234, 32'h00221820, 1'b0, 1'b0);
    @(negedge clk);
    check_output("count_after_add", 64'(count), 64'd1);

    pulse_start();
    check_output("count_after_restart", 64'(count), 64'd0);
    apply_stimulus(3'd4, 5'd0, 5'd8, 5'd17, 16'h0004, 32'h8C080004, 1'b1, 1'b0);
    apply_stimulus(3'd5, 5'd29, 5'd31, 5'd9, 16'hFFFC, 32'hAFBFFFFC, 1'b0, 1'b0);
    @(negedge clk);
    check_output("b2b_gap", 64'(last_gap), 64'd2);
    check_output("count_after_lwsw", 64'(count), 64'd2);

    apply_stimulus(3'd6, 5'd4, 5'd5, 5'd0, 16'hFFFF, 32'h1085FFFF, 1'b0, 1'b0);
    @(negedge clk);
    apply_stimulus(3'd7, 5'd1, 5'd1, 5'd1, 16'h0001, 32'h0, 1'b0, 1'b0);
    check_output("err_illegal_set", 64'(err_illegal), 64'd1);
    check_output("count_after_illegal", 64'(count), 64'd3);
    @(negedge clk);
    check_output("illegal_stays_load", 64'(req_ready), 64'd1);
    pulse_start();
    check_output("err_cleared_by_start", 64'(err_illegal), 64'd0);

    apply_stimulus(3'd1, 5'd5, 5'd6, 5'd7, 16'h0, ref_word(3'd1, 5'd5, 5'd6, 5'd7, 16'h0), 1'b0, 1'b0);
    apply_stimulus(3'd2, 5'd8, 5'd9, 5'd10, 16'h0, ref_word(3'd2, 5'd8, 5'd9, 5'd10, 16'h0), 1'b0, 1'b0);
    apply_stimulus(3'd3, 5'd11, 5'd12, 5'd13, 16'h0, ref_word(3'd3, 5'd11, 5'd12, 5'd13, 16'h0), 1'b0, 1'b0);
    apply_stimulus(3'd4, 5'd30, 5'd2, 5'd0, 16'h8000, ref_word(3'd4, 5'd30, 5'd2, 5'd0, 16'h8000), 1'b0, 1'b0);
    @(negedge clk);
    check_output("full_set", 64'(full), 64'd1);
    check_output("count_at_depth", 64'(count), 64'd4);
    req_kind = 3'd0; req_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_output("full_stalls_ready", 64'(req_ready), 64'd0);
    check_output("full_no_overwrite", 64'(count), 64'd4);
    req_valid = 1'b0;

    pulse_start();
    apply_stimulus(3'd0, 5'd9, 5'd10, 5'd11, 16'h0, ref_word(3'd0, 5'd9, 5'd10, 5'd11, 16'h0), 1'b0, 1'b1);
    check_output("done_low_in_write", 64'(done), 64'd0);
    @(negedge clk);
    check_output("done_low_after_write", 64'(done), 64'd0);
    check_output("count_before_done", 64'(count), 64'd1);
    @(negedge clk);
    check_output("done_set", 64'(done), 64'd1);
    check_output("done_not_ready", 64'(req_ready), 64'd0);
    pulse_start();
    check_output("done_cleared", 64'(done), 64'd0);
    check_output("count_cleared", 64'(count), 64'd0);
    check_output("restart_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check_output("no_stale_finish", 64'(done), 64'd0);

    apply_stimulus(3'd0, 5'd12, 5'd13, 5'd14, 16'h0, ref_word(3'd0, 5'd12, 5'd13, 5'd14, 16'h0), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_output("reset_drops_we", 64'(imem_we), 64'd0);
    check_output("reset_mid_write_outputs",
                 64'({req_ready, imem_we, imem_addr, imem_wdata, count, full, err_illegal, done}), 64'd0);
    mcount = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_output("post_reset_idle", 64'(req_ready), 64'd0);
    check_output("post_reset_count", 64'(count), 64'd0);
    req_valid = 1'b0;
    pulse_start();
    apply_stimulus(3'd3, 5'd1, 5'd1, 5'd1, 16'h0, ref_word(3'd3, 5'd1, 5'd1, 5'd1, 16'h0), 1'b0, 1'b0);
    @(negedge clk);
    check_output("count_after_reset_session", 64'(count), 64'd1);
    check_output("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
